prime_generator: RTL and testbench
==================================

PRIME_GENERATOR -- requirements
Module: prime_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the candidate, limit and result width in bits (WIDTH >= 3).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin a run; sampled only in IDLE or DONE.
REQ-005 SHALL have port limit  input  WIDTH  inclusive upper bound of candidates; sampled on the accepted start cycle.
REQ-006 SHALL have port ready  input  1  consumer accepts prime when ready and valid are both high.
REQ-007 SHALL have port prime  output  WIDTH  current prime value.
REQ-008 SHALL have port valid  output  1  prime holds a result awaiting acceptance.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE is entered.
REQ-010 SHALL have port done  output  1  level, high in DONE until the next accepted start.
REQ-011 SHALL have port count  output  WIDTH  number of primes accepted by the consumer in the current run.

Function
REQ-012 SHALL implement FSM states IDLE, INIT, CHECK, MOD, EMIT, ADVANCE, DONE.
REQ-013 IDLE/DONE + start: latch limit, clear count and done, set candidate=2, go to INIT; start in other states SHALL be ignored.
REQ-014 INIT: if latched limit < 2, go to DONE with no emission; otherwise set divisor=2, remainder=candidate, go to CHECK.
REQ-015 CHECK: divisor*divisor computed at 2*WIDTH bits (no overflow); if > candidate, candidate is prime -> EMIT; else remainder=candidate, go to MOD.
REQ-016 MOD: one subtraction per cycle; while remainder >= divisor, remainder -= divisor; when remainder < divisor: remainder==0 -> composite -> ADVANCE; else divisor+=1 -> CHECK.
REQ-017 EMIT: prime=candidate and valid=1; prime SHALL remain stable while valid && !ready; on valid && ready, count+=1, valid=0 the next cycle, go to ADVANCE.
REQ-018 ADVANCE: if candidate == latched limit -> DONE; else candidate+=1, divisor=2 -> CHECK; candidate SHALL never wrap, including limit = 2^WIDTH-1.
REQ-019 Primes SHALL be emitted strictly ascending, each exactly once, all primes in [2, limit] and nothing else.
REQ-020 ready while valid is low SHALL have no effect; valid SHALL never be high outside EMIT.
REQ-021 Changes on limit after the start cycle SHALL not affect the run.
REQ-022 prime SHALL retain the last emitted value after acceptance and in DONE.

Reset
REQ-023 rst high SHALL asynchronously force state=IDLE, prime=0, valid=0, busy=0, done=0, count=0, and clear candidate/divisor/remainder.
REQ-024 rst asserted mid-run SHALL abort the run with no further emission; the first start after rst release SHALL begin a fresh run.
REQ-025 start SHALL be ignored in any cycle rst is high.

Verification
REQ-026 limit=13, ready tied high, pulse start -> valid pulses carrying 2,3,5,7,11,13 in order, then done=1, busy=0, count=6.
REQ-027 limit=1 (and separately limit=0), pulse start -> no valid, done=1 within 3 cycles, count=0.
REQ-028 limit=13, ready low 10 cycles after first valid -> prime holds 2 with valid=1 throughout; raising ready -> count=1, sequence continues with 3.
REQ-029 WIDTH=8, limit=255, ready high -> 54 primes, last 251, done=1, no candidate wrap, no extra emission.
REQ-030 rst pulse while busy during limit=13 run -> all outputs 0 immediately; new start with limit=7 -> 2,3,5,7, count=4.
REQ-031 start pulsed while busy with limit=5, original limit=13 -> ignored, run still ends at 13 with count=6; start in DONE restarts cleanly.

Source files
------------

// File: rtl/prime_generator.sv
// prime_generator: walks candidates 2..limit, tests each by trial division
// (repeated subtraction, one step per cycle) and offers every prime found on
// a valid/ready output. A run is started by a pulse on start.
module prime_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             ready,
    output logic [WIDTH-1:0] prime,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_MOD,
        S_EMIT,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] prime_q, prime_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;

    // Square of the divisor is formed at double width so it can never overflow
    // while being compared against the candidate.
    logic [2*WIDTH-1:0] div_ext;
    logic [2*WIDTH-1:0] cand_ext;
    logic [2*WIDTH-1:0] div_sq;

    assign div_ext  = {{WIDTH{1'b0}}, div_q};
    assign cand_ext = {{WIDTH{1'b0}}, cand_q};
    assign div_sq   = div_ext * div_ext;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        cand_d  = cand_q;
        div_d   = div_q;
        rem_d   = rem_q;
        prime_d = prime_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lim_d   = limit;
                    count_d = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    cand_d  = WIDTH'(2);
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (lim_q < WIDTH'(2)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    div_d   = WIDTH'(2);
                    rem_d   = cand_q;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // No divisor up to sqrt(candidate) divided it: it is prime.
                if (div_sq > cand_ext) begin
                    prime_d = cand_q;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    rem_d   = cand_q;
                    state_d = S_MOD;
                end
            end
            S_MOD: begin
                if (rem_q >= div_q) begin
                    rem_d = rem_q - div_q;
                end else if (rem_q == '0) begin
                    state_d = S_ADVANCE;
                end else begin
                    div_d   = div_q + WIDTH'(1);
                    state_d = S_CHECK;
                end
            end
            S_EMIT: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + WIDTH'(1);
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                // Stop on equality so the candidate never has to step past
                // limit, which keeps limit = all-ones from wrapping.
                if (cand_q == lim_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cand_d  = cand_q + WIDTH'(1);
                    div_d   = WIDTH'(2);
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            cand_q  <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            prime_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            cand_q  <= cand_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            prime_q <= prime_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign prime = prime_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_prime_generator.sv
// Testbench for prime_generator: expected primes are queued when a run is
// started and a separate monitor pops and compares on every handshake.
module tb_prime_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] limit;
    logic       ready;
    logic [7:0] prime;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] count;

    prime_generator #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .limit (limit),
        .ready (ready),
        .prime (prime),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Monitor: every accepted output must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_prime: got %0d required none", prime);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("prime", {24'd0, prime}, {24'd0, mon_exp});
                end
            end
        end
    end

    task automatic push_list(input int n, input logic [7:0] v[16]);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic pulse_start(input logic [7:0] lim);
        @(posedge clk);
        #1;
        start = 1'b1;
        limit = lim;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_left"}, exp_q.size(), 32'd0);
    endtask

    logic [7:0] p13[16] = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] p7[16]  = '{8'd2, 8'd3, 8'd5, 8'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit composite[256];

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        limit = 8'd0;
        ready = 1'b1;
        #1;
        chk("rst_prime", {24'd0, prime}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic run to 13, limit input changed after start must not matter.
        push_list(6, p13);
        pulse_start(8'd13);
        limit = 8'd3;
        chk("run13_busy", {31'd0, busy}, 32'd1);
        chk("run13_done_clr", {31'd0, done}, 32'd0);
        wait_done("run13", 2000);
        chk("run13_count", {24'd0, count}, 32'd6);
        chk("run13_last", {24'd0, prime}, 32'd13);

        // Limits below 2 finish without emitting anything.
        for (int k = 0; k < 2; k++) begin
            pulse_start(8'(1 - k));
            for (int i = 0; i < 3; i++) begin
                if (done !== 1'b1) begin
                    @(posedge clk);
                    #1;
                end
            end
            chk("small_done", {31'd0, done}, 32'd1);
            chk("small_count", {24'd0, count}, 32'd0);
            chk("small_valid", {31'd0, valid}, 32'd0);
        end

        // Backpressure: first prime held while ready is low.
        ready = 1'b0;
        push_list(6, p13);
        pulse_start(8'd13);
        for (int n = 0; n < 200 && valid !== 1'b1; n++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid_seen", {31'd0, valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_prime", {24'd0, prime}, 32'd2);
            chk("bp_hold_valid", {31'd0, valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_count1", {24'd0, count}, 32'd1);
        chk("bp_after_valid", {31'd0, valid}, 32'd0);
        chk("bp_after_prime", {24'd0, prime}, 32'd2);
        wait_done("bp", 2000);
        chk("bp_count", {24'd0, count}, 32'd6);

        // Start while busy is ignored; start from DONE restarts cleanly.
        push_list(6, p13);
        pulse_start(8'd13);
        repeat (20) @(posedge clk);
        pulse_start(8'd5);
        wait_done("ign", 2000);
        chk("ign_count", {24'd0, count}, 32'd6);
        chk("ign_last", {24'd0, prime}, 32'd13);
        push_list(4, p7);
        pulse_start(8'd7);
        wait_done("restart", 2000);
        chk("restart_count", {24'd0, count}, 32'd4);

        // Reset mid-run aborts; start held during reset is ignored.
        push_list(6, p13);
        pulse_start(8'd13);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_prime", {24'd0, prime}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy},  32'd0);
        chk("mid_rst_count", {24'd0, count}, 32'd0);
        exp_q.delete();
        start = 1'b1;
        limit = 8'd13;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_valid", {31'd0, valid}, 32'd0);
        push_list(4, p7);
        pulse_start(8'd7);
        wait_done("after_rst", 2000);
        chk("after_rst_count", {24'd0, count}, 32'd4);

        // Full range: every prime up to 255 from an independent sieve.
        for (int i = 2; i < 256; i++) begin
            if (!composite[i]) begin
                exp_q.push_back(8'(i));
                for (int j = i * i; j < 256; j += i) composite[j] = 1'b1;
            end
        end
        pulse_start(8'd255);
        wait_done("full", 80000);
        chk("full_count", {24'd0, count}, 32'd54);
        chk("full_last", {24'd0, prime}, 32'd251);
        repeat (5) @(posedge clk);
        #1;
        chk("full_idle_valid", {31'd0, valid}, 32'd0);
        chk("full_stay_done", {31'd0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
